// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Next-PC controller for the 5-stage MIPS pipeline. Every cycle it picks the
//   value loaded into the PC register (reset vector, pc+4, branch/jump target
//   or hold). It also drives the IF/ID write enable and the IF/ID and ID/EX
//   flush strobes for load-use hazards, instruction-memory wait states and
//   control-flow redirects.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   pc_cur                     current PC (PC register output)
//   imem_ready                 instruction memory holds valid data for pc_cur
//   branch_taken/_target       branch resolved taken in EX and its target
//   jump/jump_target           J/JAL decoded in ID and its target
//   idex_memread, idex_rt      load in EX and its destination register
//   ifid_rs, ifid_rt           source registers of the instruction in ID
//   pc_in                      next PC value (drives PC register PC_IN)
//   ifid_write                 IF/ID load enable
//   ifid_flush, idex_flush     clear IF/ID / ID/EX to NOP
//   stall_count                saturating count of hold cycles
//   state                      current FSM state
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc_cur,
   input  logic             imem_ready,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   output logic [31:0]      pc_in,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      HAZARD  = 2'd2,
      MEMWAIT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic             load_use;
   logic             hold;
   logic [31:0]      pc_plus4;

   assign load_use = idex_memread && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
   assign pc_plus4 = pc_cur + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stall_count_q <= stall_count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_in      = pc_plus4;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      hold       = 1'b0;

      case (state_q)
         BOOT: begin
            pc_in      = RESET_VECTOR;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
         end

         RUN, MEMWAIT: begin
            if (branch_taken) begin
               // Branch is the older instruction, so it wins over a jump.
               pc_in      = branch_target;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               state_d    = RUN;
            end else if (jump) begin
               pc_in      = jump_target;
               ifid_flush = 1'b1;
               state_d    = RUN;
            end else if (!imem_ready) begin
               pc_in      = pc_cur;
               ifid_write = 1'b0;
               hold       = 1'b1;
               state_d    = MEMWAIT;
            end else if (load_use && (state_q == RUN)) begin
               // While leaving MEMWAIT a load-use never adds a second bubble.
               pc_in      = pc_cur;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
               hold       = 1'b1;
               state_d    = HAZARD;
            end else begin
               state_d    = RUN;
            end
         end

         HAZARD: begin
            // Exactly one bubble: jump and load_use are ignored here because
            // the ID instruction re-presents on the next cycle.
            if (branch_taken) begin
               pc_in      = branch_target;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               state_d    = RUN;
            end else if (!imem_ready) begin
               pc_in      = pc_cur;
               ifid_write = 1'b0;
               hold       = 1'b1;
               state_d    = MEMWAIT;
            end else begin
               state_d    = RUN;
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // Saturate at all-ones instead of wrapping.
   always_comb begin
      stall_count_d = stall_count_q;
      if (hold && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_count = stall_count_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_cur;
   logic        imem_ready;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        idex_memread;
   logic [4:0]  idex_rt;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic [31:0] pc_in;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_flush;
   logic [15:0] stall_count;
   logic [1:0]  state;

   int tests = 0;
   int fails = 0;

   pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .imem_ready(imem_ready),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .idex_memread(idex_memread),
      .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .pc_in(pc_in), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .stall_count(stall_count), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic        br;
      logic [31:0] brt;
      logic        j;
      logic [31:0] jt;
      logic        mr;
      logic [4:0]  ert;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] pc;
      logic [31:0] e_pc;
      logic        e_wr;
      logic        e_iff;
      logic        e_idf;
      logic [1:0]  e_st;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_ready = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
      jump = 1'b0; jump_target = 32'h0; idex_memread = 1'b0;
      idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
   endtask

   task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic e_wr,
                             input logic e_iff, input logic e_idf, input logic [1:0] e_st,
                             input logic [15:0] e_cnt);
      check({tag, ".pc_in"}, pc_in, e_pc);
      check({tag, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, e_wr});
      check({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, e_iff});
      check({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, e_idf});
      check({tag, ".state"}, {30'd0, state}, {30'd0, e_st});
      check({tag, ".stall_count"}, {16'd0, stall_count}, {16'd0, e_cnt});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      pc_cur = 32'h0;
      tick();
      tick();
   endtask

   initial begin
      logic [31:0] expc;
      // Behavioural reference model state
      int          m_st;
      int          m_cnt;
      int          act;
      bit          lu;
      logic [31:0] m_pc;
      bit          m_wr, m_iff, m_idf;

      idle_inputs();
      pc_cur = 32'h0;
      rst_n  = 1'b0;
      #2;
      check("async_reset.state", {30'd0, state}, 32'd0);
      tick();
      check("reset.pc_in", pc_in, 32'h0);
      check("reset.stall_count", {16'd0, stall_count}, 32'd0);

      // Boot sequence with pc_cur tracking pc_in: 0,4,8,C
      rst_n = 1'b1;
      #1;
      check_outs("boot0", 32'h0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd0);
      expc = 32'h0;
      for (int i = 1; i < 4; i++) begin
         tick();
         pc_cur = expc;
         #1;
         expc = expc + 32'd4;
         check_outs($sformatf("boot%0d", i), expc, 1'b1, 1'b0, 1'b0, 2'd1, 16'd0);
      end

      // Directed vector table, applied consecutively from RUN
      //                rdy br brt          j  jt           mr ert   rs    rt    pc             e_pc          wr iff idf st     cnt
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b1,5'd5,5'd5,5'd0,32'h20,       32'h20,       1'b0,1'b0,1'b1,2'd1,16'd0});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b1,5'd5,5'd5,5'd0,32'h20,       32'h24,       1'b1,1'b0,1'b0,2'd2,16'd1});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b1,5'd0,5'd0,5'd0,32'h24,       32'h28,       1'b1,1'b0,1'b0,2'd1,16'd1});
      vecs.push_back('{1'b1,1'b1,32'h100,   1'b1,32'h200,   1'b0,5'd0,5'd0,5'd0,32'h40,       32'h100,      1'b1,1'b1,1'b1,2'd1,16'd1});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b1,32'h200,   1'b0,5'd0,5'd0,5'd0,32'h100,      32'h200,      1'b1,1'b1,1'b0,2'd1,16'd1});
      vecs.push_back('{1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,5'd0,5'd0,5'd0,32'h80,       32'h80,       1'b0,1'b0,1'b0,2'd1,16'd1});
      vecs.push_back('{1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,5'd0,5'd0,5'd0,32'h80,       32'h80,       1'b0,1'b0,1'b0,2'd3,16'd2});
      vecs.push_back('{1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,5'd0,5'd0,5'd0,32'h80,       32'h80,       1'b0,1'b0,1'b0,2'd3,16'd3});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b0,5'd0,5'd0,5'd0,32'h80,       32'h84,       1'b1,1'b0,1'b0,2'd3,16'd4});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b0,5'd0,5'd0,5'd0,32'hFFFF_FFFC,32'h0,        1'b1,1'b0,1'b0,2'd1,16'd4});
      vecs.push_back('{1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,5'd0,5'd0,5'd0,32'h50,       32'h50,       1'b0,1'b0,1'b0,2'd1,16'd4});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b1,5'd5,5'd5,5'd0,32'h50,       32'h54,       1'b1,1'b0,1'b0,2'd3,16'd5});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b1,5'd5,5'd0,5'd5,32'h60,       32'h60,       1'b0,1'b0,1'b1,2'd1,16'd5});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b1,32'h200,   1'b1,5'd5,5'd0,5'd5,32'h60,       32'h64,       1'b1,1'b0,1'b0,2'd2,16'd6});
      vecs.push_back('{1'b1,1'b0,32'h0,     1'b0,32'h0,     1'b1,5'd7,5'd7,5'd0,32'h70,       32'h70,       1'b0,1'b0,1'b1,2'd1,16'd6});
      vecs.push_back('{1'b0,1'b0,32'h0,     1'b0,32'h0,     1'b0,5'd0,5'd0,5'd0,32'h70,       32'h70,       1'b0,1'b0,1'b0,2'd2,16'd7});
      vecs.push_back('{1'b0,1'b1,32'h300,   1'b0,32'h0,     1'b0,5'd0,5'd0,5'd0,32'h70,       32'h300,      1'b1,1'b1,1'b1,2'd3,16'd8});

      foreach (vecs[k]) begin
         tick();
         imem_ready = vecs[k].rdy; branch_taken = vecs[k].br; branch_target = vecs[k].brt;
         jump = vecs[k].j; jump_target = vecs[k].jt; idex_memread = vecs[k].mr;
         idex_rt = vecs[k].ert; ifid_rs = vecs[k].rs; ifid_rt = vecs[k].rt; pc_cur = vecs[k].pc;
         #1;
         check_outs($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_wr, vecs[k].e_iff,
                    vecs[k].e_idf, vecs[k].e_st, vecs[k].e_cnt);
      end
      tick();
      idle_inputs();
      #1;
      check("after_table.state", {30'd0, state}, 32'd1);
      check("after_table.stall_count", {16'd0, stall_count}, 32'd8);

      // Long memory wait: counter must saturate, not wrap
      imem_ready = 1'b0;
      pc_cur     = 32'h80;
      for (int i = 0; i < 70000; i++) tick();
      #1;
      check("sat.stall_count", {16'd0, stall_count}, 32'h0000_FFFF);
      check("sat.state", {30'd0, state}, 32'd3);
      check("sat.pc_in", pc_in, 32'h80);

      // Asynchronous reset in the middle of MEMWAIT, checked before any edge
      rst_n = 1'b0;
      #1;
      check("midreset.state", {30'd0, state}, 32'd0);
      check("midreset.stall_count", {16'd0, stall_count}, 32'd0);
      check("midreset.pc_in", pc_in, 32'h0);
      check("midreset.idex_flush", {31'd0, idex_flush}, 32'd1);

      // Randomized run against the reference model
      do_reset();
      rst_n = 1'b1;
      m_st  = 0;
      m_cnt = 0;
      m_pc  = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         imem_ready    = ($urandom_range(0, 3) != 0);
         branch_taken  = ($urandom_range(0, 7) == 0);
         branch_target = $urandom & 32'hFFFF_FFFC;
         jump          = ($urandom_range(0, 7) == 0);
         jump_target   = $urandom & 32'hFFFF_FFFC;
         idex_memread  = ($urandom_range(0, 1) == 1);
         idex_rt       = 5'($urandom_range(0, 3));
         ifid_rs       = 5'($urandom_range(0, 3));
         ifid_rt       = 5'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) pc_cur = $urandom;
         else                           pc_cur = m_pc;
         #1;

         lu = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
         // actions: 0 boot, 1 branch, 2 jump, 3 memory hold, 4 bubble, 5 advance
         if (m_st == 0)                   act = 0;
         else if (branch_taken)           act = 1;
         else if (jump && m_st != 2)      act = 2;
         else if (!imem_ready)            act = 3;
         else if (lu && m_st == 1)        act = 4;
         else                             act = 5;

         case (act)
            0:       m_pc = 32'h0;
            1:       m_pc = branch_target;
            2:       m_pc = jump_target;
            3, 4:    m_pc = pc_cur;
            default: m_pc = 32'((64'(pc_cur) + 64'd4) % 64'h1_0000_0000);
         endcase
         m_wr  = (act == 1 || act == 2 || act == 5);
         m_iff = (act == 0 || act == 1 || act == 2);
         m_idf = (act == 0 || act == 1 || act == 4);

         check_outs($sformatf("rnd%0d", i), m_pc, m_wr, m_iff, m_idf, 2'(m_st), 16'(m_cnt));

         if ((act == 3 || act == 4) && m_cnt < 65535) m_cnt++;
         m_st = (act == 3) ? 3 : (act == 4) ? 2 : 1;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 5-stage MIPS pipeline. Each cycle it computes the value loaded into the PC register: reset vector, sequential +4, branch/jump target, or hold.
- Generates IF/ID write-enable and the IF/ID and ID/EX flush strobes for load-use hazards, instruction-memory wait states and control-flow redirects.
- Sits between the hazard/branch logic and the PC register. Its pc_in output drives the PC register's PC_IN directly, and the PC register's control input is tied 0.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_cur  in  32  current PC (PC register output).
- imem_ready  in  1  instruction memory has valid data for pc_cur.
- branch_taken  in  1  branch resolved taken in EX.
- branch_target  in  32  branch target from EX.
- jump  in  1  J/JAL decoded in ID.
- jump_target  in  32  jump target from ID.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  5  load destination register.
- ifid_rs  in  5  rs of the instruction in ID.
- ifid_rt  in  5  rt of the instruction in ID.
- pc_in  out  32  next PC value.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_flush  out  1  clear ID/EX to NOP (bubble).
- stall_count  out  CNT_W  saturating count of hold cycles.
- state  out  2  current FSM state.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Registered: FSM state, stall_count. All other outputs are combinational from state and inputs (Mealy), valid in the same cycle.
- State encoding: BOOT=0, RUN=1, HAZARD=2, MEMWAIT=3.
- Reset (rst_n=0, any time including mid-stall): state=BOOT, stall_count=0, immediately.
- BOOT outputs: pc_in=RESET_VECTOR, ifid_write=0, ifid_flush=1, idex_flush=1. Next state is RUN unconditionally.
- load_use = idex_memread & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- RUN and MEMWAIT priority, highest first:
  1. branch_taken: pc_in=branch_target, ifid_flush=1, idex_flush=1, ifid_write=1. Next state RUN. Branch beats a simultaneous jump (older instruction).
  2. jump: pc_in=jump_target, ifid_flush=1, idex_flush=0, ifid_write=1. Next state RUN.
  3. imem_ready=0: pc_in=pc_cur, ifid_write=0, no flushes. Next state MEMWAIT.
  4. load_use (RUN only): pc_in=pc_cur, ifid_write=0, idex_flush=1. Next state HAZARD.
  5. Otherwise: pc_in=pc_cur+4 (mod 2^32, wraps FFFF_FFFC to 0000_0000), ifid_write=1, no flushes. Next state RUN.
- HAZARD (exactly one bubble):
  - branch_taken is handled as in rule 1.
  - jump and load_use are ignored; the ID instruction re-presents next cycle.
  - If imem_ready=0, go to MEMWAIT with hold.
  - Otherwise pc_in=pc_cur+4, ifid_write=1, next state RUN.
- MEMWAIT exits to RUN on the first cycle imem_ready=1 via rule 5. While waiting, load_use does not raise a second bubble.
- stall_count increments on each clock edge where pc_in==pc_cur was selected by a hold rule (3, 4). It saturates at all-ones and never wraps. BOOT cycles are not counted.
- No X on outputs in any state. pc_in depends on pc_cur only in hold and +4 cases.

Test Plan:
1. rst_n low then released, imem_ready=1, no hazards, pc_cur tracking pc_in → pc_in=0,4,8,C over cycles; cycle 0 has ifid_flush=1 and idex_flush=1; state sequence 0,1,1,1.
2. RUN with pc_cur=0x20, idex_memread=1, idex_rt=5, ifid_rs=5 held 2 cycles → one cycle of pc_in=0x20, ifid_write=0, idex_flush=1, state=2; then pc_in=0x24, state=1; stall_count=1. Repeat with idex_rt=0 → no stall.
3. pc_cur=0x40, branch_taken=1, target=0x100, jump=1, jump_target=0x200 same cycle → pc_in=0x100, ifid_flush=1, idex_flush=1. Jump alone → pc_in=0x200, idex_flush=0.
4. imem_ready=0 for 3 cycles at pc_cur=0x80 → pc_in=0x80 and ifid_write=0 for 3 cycles, state=3; stall_count +3. Then pc_in=0x84.
5. pc_cur=0xFFFF_FFFC, normal flow → pc_in=0x0000_0000. Force 70000 memwait cycles with CNT_W=16 → stall_count holds 0xFFFF.
6. rst_n pulsed low mid-MEMWAIT → state=0, stall_count=0, pc_in=RESET_VECTOR asynchronously, before any clock edge.
